fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of one FIFO among NUM_REQ independent requesters.
- Round-robin arbitration with a bounded burst: an owner keeps the grant for up to MAX_BURST accepted beats, then must re-arbitrate.
- Sits directly in front of the FIFO's data_in / write_en / fifo_full interface.
- Requesters use a req/ack handshake. Data is accepted in the same cycle ack is high.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, width of one data beat; must match the FIFO.
- MAX_BURST, 4, maximum accepted beats per grant (≥1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high while data is pending.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's beat in bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot, combinational; beat of requester i accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  combinational write strobe to the FIFO.
- fifo_data_in  out  DATA_WIDTH  combinational data to the FIFO; the owner's req_data slice.
- grant_valid  out  1  registered; a grant is active.
- grant_id  out  $clog2(NUM_REQ)  registered; current or last owner index.

Behaviour:
- One clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values:
  - State IDLE, grant_valid=0, grant_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - beat_cnt=0.
  - While reset is high, ack=0 and fifo_write_en=0 regardless of state.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Next edge: owner←winner, grant_valid←1, grant_id←winner, beat_cnt←0, state←GRANT.
  - No ack or write occurs in IDLE. Arbitration latency is one cycle.
- GRANT, beat accepted when req[owner] && !fifo_full:
  - ack[owner]=1.
  - fifo_write_en=1.
  - fifo_data_in = owner slice.
  - beat_cnt increments.
- GRANT, stall when req[owner] && fifo_full:
  - No ack, no write.
  - beat_cnt holds and grant is held indefinitely.
- GRANT, release (next edge → IDLE, grant_valid←0, last_grant←owner, grant_id holds) when either:
  - req[owner]==0 in GRANT (no beat accepted that cycle), or
  - a beat is accepted with beat_cnt==MAX_BURST-1.
- One IDLE bubble always separates consecutive grants, including re-grant to the same requester when it is the only one pending.
- Requests from non-owners are ignored during GRANT; their ack stays 0.
- beat_cnt width is $clog2(MAX_BURST+1); it never wraps.
- fifo_data_in is don't-care when fifo_write_en=0. The implementation drives the owner slice.
- Reset mid-burst:
  - The cycle with reset high performs no write.
  - The following cycle is IDLE with requester 0 at top priority.
  - The partial burst is not resumed or accounted for.
- Requesters must hold req_data stable while req is high and ack is low.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - State enum (IDLE, GRANT).
  - Helper constant for the grant index width.
- One sub-module is natural: rr_priority_pick (combinational, parameterized NUM_REQ).
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Reused by later read-side schedulers.

Test Plan:
- Reset, then req0 high with beats 0xA0,0xA1,0xA2, dropping req after the third ack → grant_valid at cycle 1; ack0/fifo_write_en in cycles 1-3; FIFO receives A0,A1,A2 in order; cycle 4 releases to IDLE.
- All four req continuously high, MAX_BURST=4, fifo_full=0 → grant order 0,1,2,3,0; exactly 4 acks per grant; one idle cycle between grants; no ack to a non-owner.
- Owner 1 mid-burst after 2 beats, fifo_full high for 3 cycles → no write_en or ack for those 3 cycles; grant held; 2 more beats accepted after full drops, then release.
- last_grant=1 with req0 and req3 pending → requester 3 granted (scan order 2,3,0).
- Requester 2 drops req after 1 of 4 beats while req0 is pending → release after one beat; requester 0 granted next.
- Reset asserted during owner 3's second beat → no write that cycle; after reset, with req0 and req3 both high, requester 0 granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and related schedulers.
package fifo_arb_pkg;

    // Arbiter FSM: waiting to arbitrate, or an owner holds the write port.
    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: first set request after last_grant, wrapping.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_grant,
    output logic [IdxW-1:0]    winner,
    output logic               any_req
);

    // Scan last_grant+1 .. last_grant+NUM_REQ modulo NUM_REQ; first hit wins.
    always_comb begin
        int unsigned idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_req && req[idx]) begin
                winner  = IdxW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among requesters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] grant_id_q, grant_id_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            grant_valid_q, grant_valid_d;

    logic [IdxW-1:0] winner;
    logic            any_req;
    logic            owner_req;
    logic            accept;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Datapath and handshake: the owner's beat goes straight through when the FIFO has room.
    always_comb begin
        owner_req     = req[grant_id_q];
        accept        = (state_q == StGrant) && owner_req && !fifo_full && !reset;
        ack           = '0;
        fifo_write_en = accept;
        fifo_data_in  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        if (accept) begin
            ack[grant_id_q] = 1'b1;
        end
    end

    // Next-state: arbitrate in idle, count beats and release on drop or burst limit.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        grant_valid_d = grant_valid_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d       = StGrant;
                    grant_id_d    = winner;
                    grant_valid_d = 1'b1;
                    beat_cnt_d    = '0;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    state_d       = StIdle;
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_id_q;
                end else if (accept) begin
                    if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
                        state_d       = StIdle;
                        grant_valid_d = 1'b0;
                        last_grant_d  = grant_id_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; requester 0 gets first priority afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_id_q    <= '0;
            last_grant_q  <= IdxW'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a rule-level reference model.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = $clog2(NR);
    localparam int NCYC = 4000;

    logic               clock = 1'b0;
    logic               reset;
    logic [NR-1:0]      req;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      ack;
    logic               fifo_full;
    logic               fifo_write_en;
    logic [DW-1:0]      fifo_data_in;
    logic               grant_valid;
    logic [IW-1:0]      grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the port, who last held it, beats taken this grant.
    int m_owner;   // -1 when nobody holds a grant
    int m_last;
    int m_beats;
    int m_gid;

    // Requester stimulus: beats still to send and the beat on offer.
    int         rem [NR];
    logic [DW-1:0] cur [NR];

    // Expected FIFO contents versus what the DUT actually wrote.
    logic [DW-1:0] exp_fifo [$];
    logic [DW-1:0] got_fifo [$];
    int n_grants = 0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        logic [NR-1:0] e_ack;
        logic          e_we;
        int            w;

        m_owner = -1;
        m_last  = NR - 1;
        m_beats = 0;
        m_gid   = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            cur[i] = DW'($urandom);
        end
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            reset     = (cyc < 2) || ($urandom_range(0, 299) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) begin
                req[i]               = (rem[i] > 0);
                req_data[i*DW +: DW] = cur[i];
            end
            #1;

            // Expected combinational outputs for this cycle.
            e_ack = '0;
            e_we  = 1'b0;
            if (!reset && m_owner >= 0 && req[m_owner] && !fifo_full) begin
                e_ack[m_owner] = 1'b1;
                e_we           = 1'b1;
            end
            check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
            check_eq("grant_id", 32'(grant_id), 32'(m_gid));
            check_eq("ack", 32'(ack), 32'(e_ack));
            check_eq("write_en", 32'(fifo_write_en), 32'(e_we));
            if (e_we) begin
                check_eq("data_in", 32'(fifo_data_in), 32'(cur[m_owner]));
                exp_fifo.push_back(cur[m_owner]);
            end
            if (fifo_write_en) got_fifo.push_back(fifo_data_in);

            // Model update for the coming edge.
            if (reset) begin
                m_owner = -1;
                m_last  = NR - 1;
                m_beats = 0;
                m_gid   = 0;
            end else if (m_owner < 0) begin
                w = rr_pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_gid   = w;
                    m_beats = 0;
                    n_grants++;
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (e_we) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end

            // Requesters advance on the expected handshake; occasionally abandon or start.
            for (int i = 0; i < NR; i++) begin
                if (e_ack[i]) begin
                    rem[i]--;
                    cur[i] = DW'($urandom);
                end else if (rem[i] > 0 && $urandom_range(0, 39) == 0) begin
                    rem[i] = 0;
                    cur[i] = DW'($urandom);
                end else if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 7);
                end
            end
        end

        check_eq("fifo_count", 32'(got_fifo.size()), 32'(exp_fifo.size()));
        for (int i = 0; i < exp_fifo.size() && i < got_fifo.size(); i++) begin
            check_eq("fifo_order", 32'(got_fifo[i]), 32'(exp_fifo[i]));
        end
        check_eq("grants_seen", 32'(n_grants > 50), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
